// File: rtl/cic_interp_x10.sv
// Complex x10 CIC interpolator (N=3, M=1): low-rate I/Q enters through a valid/ready
// hold register, gain-corrected high-rate I/Q leaves as a strobe on every output tick.
module cic_interp_x10 #(
    parameter int                 IN_W        = 16,
    parameter int                 R           = 10,
    parameter int                 CLK_PER_OUT = 2,
    parameter int                 INT_W       = 26,
    parameter int                 SHIFT       = 7,
    parameter logic signed [15:0] GAIN        = 16'sd20972
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] s_i_data,
    input  logic [IN_W-1:0] s_q_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [IN_W-1:0] m_i_data,
    output logic [IN_W-1:0] m_q_data,
    output logic            m_valid,
    output logic            underrun,
    input  logic            clr_underrun
);
    localparam int PW = INT_W - SHIFT + 16;
    localparam logic signed [PW-1:0] RND    = PW'(2**13);
    localparam logic signed [PW-1:0] SAT_HI = PW'(2**(IN_W-1) - 1);
    localparam logic signed [PW-1:0] SAT_LO = PW'(-(2**(IN_W-1)));
    localparam logic [IN_W-1:0]      OUT_HI = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic [IN_W-1:0]      OUT_LO = {1'b1, {(IN_W-1){1'b0}}};

    logic [3:0]            phase_cnt;
    logic [3:0]            slot_cnt;
    logic                  tick;
    logic                  slot_tick;
    logic                  xfer;
    logic                  hold_valid;
    logic [IN_W-1:0]       hold_i;
    logic [IN_W-1:0]       hold_q;
    logic                  inject;
    logic signed [INT_W-1:0] x [2];
    logic signed [INT_W-1:0] c1 [2];
    logic signed [INT_W-1:0] c2 [2];
    logic signed [INT_W-1:0] c3 [2];
    logic signed [INT_W-1:0] d1 [2];
    logic signed [INT_W-1:0] d2 [2];
    logic signed [INT_W-1:0] d3 [2];
    logic signed [INT_W-1:0] comb_out [2];
    logic signed [INT_W-1:0] int1 [2];
    logic signed [INT_W-1:0] int2 [2];
    logic signed [INT_W-1:0] int3 [2];

    function automatic logic signed [INT_W-1:0] sext(input logic [IN_W-1:0] v);
        return {{(INT_W-IN_W){v[IN_W-1]}}, v};
    endfunction

    // Scale, apply Q2.14 gain, round half-up and clip to the output width.
    function automatic logic [IN_W-1:0] gain_sat(input logic signed [INT_W-1:0] acc);
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] rnd;
        prod = PW'(acc >>> SHIFT) * PW'(GAIN);
        rnd  = (prod + RND) >>> 14;
        if (rnd > SAT_HI)      return OUT_HI;
        else if (rnd < SAT_LO) return OUT_LO;
        else                   return rnd[IN_W-1:0];
    endfunction

    assign tick      = (phase_cnt == 4'(CLK_PER_OUT - 1));
    assign slot_tick = tick && (slot_cnt == 4'd0);
    assign s_ready   = !hold_valid;
    assign xfer      = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
            slot_cnt  <= '0;
        end else begin
            phase_cnt <= tick ? 4'd0 : phase_cnt + 4'd1;
            if (tick) slot_cnt <= (slot_cnt == 4'(R - 1)) ? 4'd0 : slot_cnt + 4'd1;
        end
    end

    // A load can only coincide with a consume when the register was empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_i     <= '0;
            hold_q     <= '0;
            underrun   <= 1'b0;
        end else begin
            if (xfer) begin
                hold_valid <= 1'b1;
                hold_i     <= s_i_data;
                hold_q     <= s_q_data;
            end else if (slot_tick) begin
                hold_valid <= 1'b0;
            end
            if (slot_tick && !hold_valid) underrun <= 1'b1;
            else if (clr_underrun)        underrun <= 1'b0;
        end
    end

    always_comb begin
        x[0] = hold_valid ? sext(hold_i) : '0;
        x[1] = hold_valid ? sext(hold_q) : '0;
        for (int k = 0; k < 2; k++) begin
            c1[k] = x[k] - d1[k];
            c2[k] = c1[k] - d2[k];
            c3[k] = c2[k] - d3[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                d1[k]       <= '0;
                d2[k]       <= '0;
                d3[k]       <= '0;
                comb_out[k] <= '0;
                int1[k]     <= '0;
                int2[k]     <= '0;
                int3[k]     <= '0;
            end
            inject <= 1'b0;
        end else begin
            if (slot_tick) begin
                for (int k = 0; k < 2; k++) begin
                    d1[k]       <= x[k];
                    d2[k]       <= c1[k];
                    d3[k]       <= c2[k];
                    comb_out[k] <= c3[k];
                end
            end
            if (tick) begin
                for (int k = 0; k < 2; k++) begin
                    int1[k] <= int1[k] + (inject ? comb_out[k] : '0);
                    int2[k] <= int2[k] + int1[k];
                    int3[k] <= int3[k] + int2[k];
                end
            end
            // Comb result is injected on the tick after the slot tick, then zero-stuffed.
            if (slot_tick) inject <= 1'b1;
            else if (tick) inject <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_i_data <= '0;
            m_q_data <= '0;
            m_valid  <= 1'b0;
        end else begin
            m_valid <= tick;
            if (tick) begin
                m_i_data <= gain_sat(int3[0]);
                m_q_data <= gain_sat(int3[1]);
            end
        end
    end
endmodule

// File: tb/tb_cic_interp_x10.sv
// Bench for cic_interp_x10: expected outputs come from a direct convolution of the
// zero-stuffed consumed samples with the box^3 impulse response.
module tb_cic_interp_x10;
    localparam int CPO    = 2;
    localparam int RR     = 10;
    localparam int PERIOD = CPO * RR;
    localparam int NT     = 28;
    localparam int NSLOT  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_i_data = '0;
    logic [15:0] s_q_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] m_i_data;
    logic [15:0] m_q_data;
    logic        m_valid;
    logic        underrun;
    logic        clr_underrun = 1'b0;

    cic_interp_x10 dut (
        .clk(clk), .rst_n(rst_n),
        .s_i_data(s_i_data), .s_q_data(s_q_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_i_data(m_i_data), .m_q_data(m_q_data), .m_valid(m_valid),
        .underrun(underrun), .clr_underrun(clr_underrun)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    int          e_cnt;
    int          cur_t;
    int          next_off;
    bit          exp_valid;
    bit          exp_und;
    bit          last_xfer;
    logic [15:0] exp_i;
    logic [15:0] exp_q;
    logic [15:0] slot_i [NSLOT];
    logic [15:0] slot_q [NSLOT];
    logic [15:0] pend_i [$];
    logic [15:0] pend_q [$];
    int          h [NT];

    function automatic logic [15:0] model_out(input int t, input bit q);
        longint acc;
        longint p;
        int     n;
        acc = 0;
        for (int j = 0; (j * RR <= t - 4) && (j < NSLOT); j++) begin
            n = t - 4 - j * RR;
            if (n < NT)
                acc += longint'(h[n]) * (q ? longint'($signed(slot_q[j])) : longint'($signed(slot_i[j])));
        end
        p = ((acc >>> 7) * 20972 + 8192) >>> 14;
        if (p > 32767)  return 16'h7FFF;
        if (p < -32768) return 16'h8000;
        return 16'(p);
    endfunction

    task automatic reset_model();
        e_cnt = 0;
        cur_t = -1;
        exp_valid = 1'b0;
        exp_und = 1'b0;
        exp_i = '0;
        exp_q = '0;
        pend_i.delete();
        pend_q.delete();
        foreach (slot_i[j]) begin
            slot_i[j] = '0;
            slot_q[j] = '0;
        end
        next_off = $urandom_range(PERIOD - 1, 1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        s_valid = 1'b0;
        clr_underrun = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        reset_model();
    endtask

    // Drive one clock from a falling edge and advance the reference to the next falling edge.
    task automatic step(input logic v, input logic [15:0] di, input logic [15:0] dq, input logic clr);
        int t;
        bit set_und;
        s_valid = v;
        s_i_data = di;
        s_q_data = dq;
        clr_underrun = clr;
        last_xfer = v && (pend_i.size() == 0);
        @(posedge clk);
        e_cnt++;
        exp_valid = (e_cnt % CPO == 0);
        set_und = 1'b0;
        if (exp_valid) begin
            t = e_cnt / CPO - 1;
            cur_t = t;
            if ((t % RR == 0) && (t / RR < NSLOT)) begin
                if (pend_i.size() > 0) begin
                    slot_i[t / RR] = pend_i.pop_front();
                    slot_q[t / RR] = pend_q.pop_front();
                end else begin
                    slot_i[t / RR] = '0;
                    slot_q[t / RR] = '0;
                    set_und = 1'b1;
                end
            end
            exp_i = model_out(t, 1'b0);
            exp_q = model_out(t, 1'b1);
        end
        if (set_und)  exp_und = 1'b1;
        else if (clr) exp_und = 1'b0;
        if (last_xfer) begin
            pend_i.push_back(di);
            pend_q.push_back(dq);
        end
        @(negedge clk);
    endtask

    // Offer one sample per input slot at a random clock inside the slot window.
    task automatic drive_slot(input logic [15:0] di, input logic [15:0] dq);
        logic v;
        v = ((e_cnt + 1 - 2) % PERIOD == next_off);
        step(v, v ? di : 16'h0, v ? dq : 16'h0, 1'b0);
        if (e_cnt % PERIOD == 2) next_off = $urandom_range(PERIOD - 1, 1);
    endtask

    function automatic int slot_of_next_edge();
        return (e_cnt + 1 - 2) / PERIOD + 1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        s_valid = 1'b0;
        clr_underrun = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0 || m_i_data !== 16'h0 || m_q_data !== 16'h0) $display("FAIL reset_outputs got %b/%h/%h exp 0/0000/0000", m_valid, m_i_data, m_q_data); else passes++;
        checks++; if (s_ready !== 1'b1 || underrun !== 1'b0) $display("FAIL reset_flags got ready=%b und=%b exp 1/0", s_ready, underrun); else passes++;
        rst_n = 1'b1;
        reset_model();
        for (int k = 0; k < 70; k++) begin
            step(1'b0, 16'h0, 16'h0, (k == 30) || (k == 61));
            checks++; if (m_valid !== exp_valid) $display("FAIL idle_valid e=%0d got %b exp %b", e_cnt, m_valid, exp_valid); else passes++;
            checks++; if (m_i_data !== 16'h0 || m_q_data !== 16'h0) $display("FAIL idle_data e=%0d got %h/%h exp 0000/0000", e_cnt, m_i_data, m_q_data); else passes++;
            checks++; if (underrun !== exp_und) $display("FAIL idle_underrun e=%0d got %b exp %b", e_cnt, underrun, exp_und); else passes++;
            if (e_cnt == 31) begin
                checks++; if (underrun !== 1'b0) $display("FAIL clr_underrun got %b exp 0", underrun); else passes++;
            end
            if (e_cnt == 42 || e_cnt == 62) begin
                checks++; if (underrun !== 1'b1) $display("FAIL underrun_reset e=%0d got %b exp 1", e_cnt, underrun); else passes++;
            end
        end
    endtask

    task automatic test_impulse();
        logic [15:0] want;
        apply_reset();
        for (int k = 0; k < 140; k++) begin
            drive_slot((slot_of_next_edge() == 1) ? 16'h4000 : 16'h0, 16'h0);
            checks++; if (m_valid !== exp_valid) $display("FAIL impulse_valid e=%0d got %b exp %b", e_cnt, m_valid, exp_valid); else passes++;
            checks++; if (m_i_data !== exp_i || m_q_data !== 16'h0) $display("FAIL impulse_data t=%0d got %h/%h exp %h/0000", cur_t, m_i_data, m_q_data, exp_i); else passes++;
            if (exp_valid && (cur_t == 14 || cur_t == 15 || cur_t == 16 || cur_t == 41 || cur_t == 42)) begin
                want = (cur_t == 14 || cur_t == 41) ? 16'd164 : (cur_t == 15) ? 16'd492 : (cur_t == 16) ? 16'd983 : 16'd0;
                checks++; if (m_i_data !== want) $display("FAIL impulse_tap t=%0d got %0d exp %0d", cur_t, m_i_data, want); else passes++;
            end
        end
    endtask

    task automatic test_dc();
        int di;
        int dq;
        apply_reset();
        for (int k = 0; k < 300; k++) begin
            drive_slot(16'h2000, 16'hE000);
            checks++; if (m_valid !== exp_valid) $display("FAIL dc_valid e=%0d got %b exp %b", e_cnt, m_valid, exp_valid); else passes++;
            checks++; if (m_i_data !== exp_i || m_q_data !== exp_q) $display("FAIL dc_data t=%0d got %h/%h exp %h/%h", cur_t, m_i_data, m_q_data, exp_i, exp_q); else passes++;
            checks++; if (s_ready !== (pend_i.size() == 0)) $display("FAIL dc_ready e=%0d got %b exp %b", e_cnt, s_ready, pend_i.size() == 0); else passes++;
            if (exp_valid && cur_t >= 40 && cur_t <= 145) begin
                di = int'($signed(m_i_data)) - 8192;
                dq = int'($signed(m_q_data)) + 8192;
                checks++; if (di > 1 || di < -1 || dq > 1 || dq < -1) $display("FAIL dc_level t=%0d got %h/%h exp 2000/E000 +-1", cur_t, m_i_data, m_q_data); else passes++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        int ndut;
        apply_reset();
        cnt = 0;
        ndut = 0;
        for (int k = 0; k < 200; k++) begin
            if (s_ready === 1'b1) ndut++;
            step(1'b1, 16'(cnt * 37 + 5), 16'(-cnt), 1'b0);
            if (last_xfer) cnt++;
            checks++; if (m_i_data !== exp_i || m_q_data !== exp_q) $display("FAIL b2b_data t=%0d got %h/%h exp %h/%h", cur_t, m_i_data, m_q_data, exp_i, exp_q); else passes++;
            checks++; if (s_ready !== (pend_i.size() == 0)) $display("FAIL b2b_ready e=%0d got %b exp %b", e_cnt, s_ready, pend_i.size() == 0); else passes++;
            checks++; if (underrun !== 1'b0) $display("FAIL b2b_underrun e=%0d got %b exp 0", e_cnt, underrun); else passes++;
        end
        checks++; if (ndut != 11) $display("FAIL b2b_transfers got %0d exp 11", ndut); else passes++;
    endtask

    task automatic test_load_on_consume();
        apply_reset();
        for (int k = 0; k < 80; k++) begin
            step((e_cnt + 1 == 22), 16'h1234, 16'h4321, 1'b0);
            checks++; if (m_i_data !== exp_i || m_q_data !== exp_q) $display("FAIL loc_data t=%0d got %h/%h exp %h/%h", cur_t, m_i_data, m_q_data, exp_i, exp_q); else passes++;
            checks++; if (underrun !== exp_und) $display("FAIL loc_underrun e=%0d got %b exp %b", e_cnt, underrun, exp_und); else passes++;
            if (e_cnt == 22 || e_cnt == 42) begin
                checks++; if (s_ready !== (e_cnt == 42)) $display("FAIL loc_hold e=%0d got ready=%b exp %b", e_cnt, s_ready, e_cnt == 42); else passes++;
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] v;
        int j;
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            j = slot_of_next_edge();
            if (j > 10) v = ($urandom_range(1, 0) == 1) ? 16'h7FFF : 16'h8000;
            else        v = (((j - 1) / 4) % 2 == 0) ? 16'h7FFF : 16'h8000;
            drive_slot(v, ~v);
            checks++; if (m_valid !== exp_valid) $display("FAIL sat_valid e=%0d got %b exp %b", e_cnt, m_valid, exp_valid); else passes++;
            checks++; if (m_i_data !== exp_i || m_q_data !== exp_q) $display("FAIL sat_data t=%0d got %h/%h exp %h/%h", cur_t, m_i_data, m_q_data, exp_i, exp_q); else passes++;
            if (exp_valid && cur_t >= 34 && cur_t <= 53) begin
                checks++; if (m_i_data !== 16'h7FFF || m_q_data !== 16'h8000) $display("FAIL sat_clip t=%0d got %h/%h exp 7FFF/8000", cur_t, m_i_data, m_q_data); else passes++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int k = 0; k < 170; k++) begin
            drive_slot(16'($urandom()), 16'($urandom()));
            checks++; if (m_i_data !== exp_i || m_q_data !== exp_q) $display("FAIL mid_pre_data t=%0d got %h/%h exp %h/%h", cur_t, m_i_data, m_q_data, exp_i, exp_q); else passes++;
        end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || m_i_data !== 16'h0 || m_q_data !== 16'h0) $display("FAIL mid_async_outputs got %b/%h/%h exp 0/0000/0000", m_valid, m_i_data, m_q_data); else passes++;
        checks++; if (s_ready !== 1'b1 || underrun !== 1'b0) $display("FAIL mid_async_flags got ready=%b und=%b exp 1/0", s_ready, underrun); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        for (int k = 0; k < 160; k++) begin
            drive_slot(16'($urandom()), 16'($urandom()));
            checks++; if (m_valid !== exp_valid) $display("FAIL mid_post_valid e=%0d got %b exp %b", e_cnt, m_valid, exp_valid); else passes++;
            checks++; if (m_i_data !== exp_i || m_q_data !== exp_q) $display("FAIL mid_post_data t=%0d got %h/%h exp %h/%h", cur_t, m_i_data, m_q_data, exp_i, exp_q); else passes++;
            checks++; if (underrun !== exp_und) $display("FAIL mid_post_underrun e=%0d got %b exp %b", e_cnt, underrun, exp_und); else passes++;
        end
    endtask

    initial begin
        // Impulse response of three cascaded length-R boxcars.
        foreach (h[n]) h[n] = 0;
        for (int a = 0; a < RR; a++)
            for (int b = 0; b < RR; b++)
                for (int c = 0; c < RR; c++)
                    h[a + b + c] += 1;
        test_reset();
        test_impulse();
        test_dc();
        test_back_to_back();
        test_load_on_consume();
        test_saturation();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
